// File: rtl/shift_arbiter_if.sv
// Requester-side bundle for shift_arbiter: operation handshake plus held response.
// The requester drives the master modport; the arbiter uses the slave modport.
interface shift_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output valid, a, shamt, op, rsp_ready,
        input  ready, rsp_valid, rsp_data
    );

    modport slave (
        input  valid, a, shamt, op, rsp_ready,
        output ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a single 32-bit shifter.
// Right shifts reuse the left shifter by reversing the operand and the result.
// One operation in flight: IDLE (arbitrate/capture) -> EXEC (compute) -> RESP (hold result).
// Build option: define SHIFT_ARITH_EN to make op 10 an arithmetic right shift;
// without it op 10 is a logical right shift and no sign-fill logic exists.
module shift_arbiter #(
    parameter bit RR_EN_P = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    shift_arbiter_if.slave  r0,
    shift_arbiter_if.slave  r1,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] a_q, a_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] result_q, result_d;

    logic        any_valid;
    logic        grant;
    logic        accept;
    logic        rsp_hs;
    logic [31:0] shift_res;

    function automatic logic [31:0] bit_rev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    // Arbitration: round-robin flips away from the last winner when both request.
    always_comb begin
        any_valid = r0.valid | r1.valid;
        if (RR_EN_P) begin
            if (r0.valid && r1.valid) begin
                grant = ~last_grant_q;
            end else begin
                grant = r1.valid;
            end
        end else begin
            grant = ~r0.valid;
        end
        accept = (state_q == StIdle) && any_valid;
        rsp_hs = (state_q == StResp) && (owner_q ? r1.rsp_ready : r0.rsp_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shared shifter; right shifts go through bit reversal on both sides.
    always_comb begin
        logic        right;
        logic [31:0] sh_in;
        logic [31:0] sh_out;
`ifdef SHIFT_ARITH_EN
        logic [31:0] fill;
`endif
        right  = (op_q != OpSll);
        sh_in  = right ? bit_rev(a_q) : a_q;
        sh_out = sh_in << shamt_q;
`ifdef SHIFT_ARITH_EN
        // Ones in the top shamt bits, used only for a negative arithmetic shift.
        fill = (op_q == OpSra && a_q[31]) ? bit_rev(~(32'hFFFF_FFFF << shamt_q)) : 32'h0;
`endif
        unique case (op_q)
            OpSll:   shift_res = sh_out;
            OpSrl:   shift_res = bit_rev(sh_out);
`ifdef SHIFT_ARITH_EN
            OpSra:   shift_res = bit_rev(sh_out) | fill;
`else
            OpSra:   shift_res = bit_rev(sh_out);
`endif
            default: shift_res = 32'h0;
        endcase
    end

    // Operand capture on accept, result capture in EXEC.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        shamt_d      = shamt_q;
        op_d         = op_q;
        result_d     = result_q;
        if (accept) begin
            owner_d      = grant;
            last_grant_d = grant;
            a_d          = grant ? r1.a     : r0.a;
            shamt_d      = grant ? r1.shamt : r0.shamt;
            op_d         = grant ? r1.op    : r0.op;
        end
        if (state_q == StExec) begin
            result_d = shift_res;
        end
    end

    // Datapath registers; last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= 32'h0;
            shamt_q      <= 5'h0;
            op_q         <= 2'b00;
            result_q     <= 32'h0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            shamt_q      <= shamt_d;
            op_q         <= op_d;
            result_q     <= result_d;
        end
    end

    // Outputs: ready only to the granted requester, response only to the owner.
    always_comb begin
        logic rsp0;
        logic rsp1;
        rsp0         = (state_q == StResp) && !owner_q;
        rsp1         = (state_q == StResp) && owner_q;
        r0.ready     = accept && !grant;
        r1.ready     = accept && grant;
        r0.rsp_valid = rsp0;
        r1.rsp_valid = rsp1;
        r0.rsp_data  = rsp0 ? result_q : 32'h0;
        r1.rsp_data  = rsp1 ? result_q : 32'h0;
        busy         = (state_q != StIdle);
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: round-robin instance plus a fixed-priority instance.
module tb_shift_arbiter;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRsv = 2'b11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic busy_f;

    always #5 clk = ~clk;

    shift_arbiter_if r0_if ();
    shift_arbiter_if r1_if ();
    shift_arbiter_if f0_if ();
    shift_arbiter_if f1_if ();

    shift_arbiter #(.RR_EN_P(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .r0      (r0_if),
        .r1      (r1_if),
        .busy    (busy)
    );

    shift_arbiter #(.RR_EN_P(1'b0)) dut_fp (
        .clk     (clk),
        .reset_n (reset_n),
        .r0      (f0_if),
        .r1      (f1_if),
        .busy    (busy_f)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s,
                                          input logic [1:0] op);
        case (op)
            OpSll:   return a << s;
            OpSrl:   return a >> s;
`ifdef SHIFT_ARITH_EN
            OpSra:   return 32'($signed(a) >>> s);
`else
            OpSra:   return a >> s;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Observation arrays, indexed by requester.
    logic        v[2], rdy[2], rv[2], rr[2];
    logic [31:0] ra[2], rd[2];
    logic [4:0]  rs[2];
    logic [1:0]  ro[2];
    assign v[0] = r0_if.valid;      assign v[1] = r1_if.valid;
    assign rdy[0] = r0_if.ready;    assign rdy[1] = r1_if.ready;
    assign rv[0] = r0_if.rsp_valid; assign rv[1] = r1_if.rsp_valid;
    assign rr[0] = r0_if.rsp_ready; assign rr[1] = r1_if.rsp_ready;
    assign ra[0] = r0_if.a;         assign ra[1] = r1_if.a;
    assign rd[0] = r0_if.rsp_data;  assign rd[1] = r1_if.rsp_data;
    assign rs[0] = r0_if.shamt;     assign rs[1] = r1_if.shamt;
    assign ro[0] = r0_if.op;        assign ro[1] = r1_if.op;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          grant_log[$];
    int          fp_log[$];
    int          acc_cyc[2];
    int          hs_cyc[2];
    bit          rsp_seen[2];

    // Monitor: push expectations on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            rsp_seen[0] <= 1'b0;
            rsp_seen[1] <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (v[n] && rdy[n]) begin
                    if (n == 0) q0.push_back(model(ra[n], rs[n], ro[n]));
                    else        q1.push_back(model(ra[n], rs[n], ro[n]));
                    grant_log.push_back(n);
                    acc_cyc[n]  <= cyc;
                    rsp_seen[n] <= 1'b0;
                end
                if (rv[n] && !rsp_seen[n]) begin
                    rsp_seen[n] <= 1'b1;
                    check("latency", 32'(cyc - acc_cyc[n]), 32'd2);
                    check("rsp_exclusive", 32'(rv[1-n]), 32'd0);
                end
                if (rv[n] && rr[n]) begin
                    hs_cyc[n] <= cyc;
                    if (n == 0) begin
                        if (q0.size() == 0) check("unexpected_rsp0", 32'd1, 32'd0);
                        else check("rsp0_data", rd[n], q0.pop_front());
                    end else begin
                        if (q1.size() == 0) check("unexpected_rsp1", 32'd1, 32'd0);
                        else check("rsp1_data", rd[n], q1.pop_front());
                    end
                end
            end
            if (f0_if.valid && f0_if.ready) fp_log.push_back(0);
            if (f1_if.valid && f1_if.ready) fp_log.push_back(1);
        end
    end

    task automatic drive(input int n, input logic vld, input logic [31:0] a,
                         input logic [4:0] s, input logic [1:0] op);
        if (n == 0) begin
            r0_if.valid = vld; r0_if.a = a; r0_if.shamt = s; r0_if.op = op;
        end else begin
            r1_if.valid = vld; r1_if.a = a; r1_if.shamt = s; r1_if.op = op;
        end
    endtask

    // Present an op and hold it until accepted; returns just after the accept edge.
    task automatic issue(input int n, input logic [31:0] a, input logic [4:0] s,
                         input logic [1:0] op);
        bit done = 1'b0;
        @(posedge clk); #1;
        drive(n, 1'b1, a, s, op);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (v[n] && rdy[n]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(n, 1'b0, 32'h0, 5'h0, 2'b00);
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy && !r0_if.valid && !r1_if.valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4] = '{0, 1, 0, 1};
        bit seen;
        logic [1:0]  rop;
        logic [31:0] ra_r;

        drive(0, 1'b0, 32'h0, 5'h0, 2'b00);
        drive(1, 1'b0, 32'h0, 5'h0, 2'b00);
        r0_if.rsp_ready = 1'b1;
        r1_if.rsp_ready = 1'b1;
        f0_if.valid = 1'b0; f0_if.a = 32'h1; f0_if.shamt = 5'd1; f0_if.op = OpSll;
        f1_if.valid = 1'b0; f1_if.a = 32'h2; f1_if.shamt = 5'd1; f1_if.op = OpSll;
        f0_if.rsp_ready = 1'b1;
        f1_if.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_r0_ready", 32'(r0_if.ready), 32'd0);
        check("rst_r1_ready", 32'(r1_if.ready), 32'd0);
        check("rst_r0_rsp_valid", 32'(r0_if.rsp_valid), 32'd0);
        check("rst_r1_rsp_valid", 32'(r1_if.rsp_valid), 32'd0);
        check("rst_r0_rsp_data", r0_if.rsp_data, 32'h0);
        check("rst_r1_rsp_data", r1_if.rsp_data, 32'h0);
        #2 reset_n = 1'b1;

        // Directed shifts
        issue(0, 32'h0000_0001, 5'd31, OpSll); wait_done();
        issue(1, 32'h8000_0000, 5'd4,  OpSrl); wait_done();
        issue(1, 32'hDEAD_BEEF, 5'd0,  OpSrl); wait_done();
        issue(0, 32'hDEAD_BEEF, 5'd0,  OpSll); wait_done();
        issue(1, 32'hDEAD_BEEF, 5'd7,  OpRsv); wait_done();
        issue(0, 32'h8000_0000, 5'd4,  OpSra); wait_done();
        issue(1, 32'h7FFF_0000, 5'd31, OpSra); wait_done();
        issue(0, 32'hC000_0001, 5'd31, OpSra); wait_done();

        // Random ops
        for (int i = 0; i < 10; i++) begin
            rop  = 2'($urandom_range(0, 3));
            ra_r = $urandom;
            issue(int'($urandom_range(0, 1)), ra_r, 5'($urandom_range(0, 31)), rop);
            wait_done();
        end

        // Both requesting continuously: RR alternates, fixed priority starves r1
        do_reset();
        grant_log.delete();
        fp_log.delete();
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h0000_00F0, 5'd2, OpSll);
        drive(1, 1'b1, 32'h0000_00F0, 5'd2, OpSrl);
        f0_if.valid = 1'b1;
        f1_if.valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (grant_log.size() >= 4) break;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 5'h0, 2'b00);
        drive(1, 1'b0, 32'h0, 5'h0, 2'b00);
        f0_if.valid = 1'b0;
        f1_if.valid = 1'b0;
        check("rr_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("rr_grant_order", 32'(grant_log[i]), 32'(exp_g[i]));
        end
        check("fp_grant_count_ge3", 32'(fp_log.size() >= 3), 32'd1);
        for (int i = 0; i < fp_log.size(); i++) begin
            check("fp_grant_r0", 32'(fp_log[i]), 32'd0);
        end
        wait_done();
        repeat (4) @(negedge clk);

        // Backpressure on r0 response while r1 waits
        r0_if.rsp_ready = 1'b0;
        issue(0, 32'h0000_F00F, 5'd8, OpSll);
        fork
            issue(1, 32'h1234_5678, 5'd4, OpSrl);
        join_none
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (r0_if.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_rsp_appears", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check("bp_rsp_valid", 32'(r0_if.rsp_valid), 32'd1);
            check("bp_rsp_data", r0_if.rsp_data, 32'h00F0_0F00);
            check("bp_r1_ready", 32'(r1_if.ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        r0_if.rsp_ready = 1'b1;
        wait_done();
        check("r1_grant_after_hs", 32'(acc_cyc[1] - hs_cyc[0]), 32'd1);

        // Reset during EXEC
        issue(0, 32'hA5A5_A5A5, 5'd3, OpSrl);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_r0_rsp_valid", 32'(r0_if.rsp_valid), 32'd0);
        check("mid_rst_r1_rsp_valid", 32'(r1_if.rsp_valid), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r0_if.rsp_valid || r1_if.rsp_valid || busy) seen = 1'b1;
        end
        check("no_rsp_after_rst", 32'(seen), 32'd0);
        issue(1, 32'h0000_0F00, 5'd4, OpSll); wait_done();
        issue(0, 32'hF000_0000, 5'd28, OpSra); wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
